// File: rtl/mt_state_bank_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mt_state_bank_pkg : MT19937 defaults and state-bank FSM encoding          |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
package mt_state_bank_pkg;

   localparam int MT_W = 32;
   localparam int MT_N = 624;
   localparam int MT_M = 397;

   localparam logic [1:0] ST_CLEAR = 2'd0;
   localparam logic [1:0] ST_IDLE  = 2'd1;
   localparam logic [1:0] ST_RD    = 2'd2;
   localparam logic [1:0] ST_WB    = 2'd3;

   typedef enum logic [1:0] {
      S_CLEAR = ST_CLEAR,
      S_IDLE  = ST_IDLE,
      S_RD    = ST_RD,
      S_WB    = ST_WB
   } state_t;

endpackage
`default_nettype wire

// File: rtl/mt_state_bank_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mt_state_bank_if : seed / tuple / write-back bundle of the state bank     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
interface mt_state_bank_if
   import mt_state_bank_pkg::*;
#(
   parameter int W  = MT_W,
   parameter int AW = $clog2(MT_N)
);
   logic          clear;
   logic          busy;
   logic          seed_we;
   logic [AW-1:0] seed_addr;
   logic [W-1:0]  seed_data;
   logic          seed_err;
   logic          req_valid;
   logic          req_ready;
   logic          tup_valid;
   logic [AW-1:0] tup_idx;
   logic [W-1:0]  x_i;
   logic [W-1:0]  x_i1;
   logic [W-1:0]  x_im;
   logic          wb_valid;
   logic [W-1:0]  wb_data;
   logic          wrap;

   modport master (
      output clear, seed_we, seed_addr, seed_data, req_valid, wb_valid, wb_data,
      input  busy, seed_err, req_ready, tup_valid, tup_idx, x_i, x_i1, x_im, wrap
   );

   modport slave (
      input  clear, seed_we, seed_addr, seed_data, req_valid, wb_valid, wb_data,
      output busy, seed_err, req_ready, tup_valid, tup_idx, x_i, x_i1, x_im, wrap
   );

endinterface
`default_nettype wire

// File: rtl/mt_ram_1w3r.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mt_ram_1w3r : W x N storage, one write port, three registered read ports  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module mt_ram_1w3r
   import mt_state_bank_pkg::*;
#(
   parameter  int W  = MT_W,
   parameter  int N  = MT_N,
   localparam int AW = $clog2(N)
) (
   input  wire logic                clk,
   input  wire logic                we,
   input  wire logic [AW-1:0]       waddr,
   input  wire logic [W-1:0]        wdata,
   input  wire logic                re,
   input  wire logic [2:0][AW-1:0]  raddr,
   output      logic [2:0][W-1:0]   rdata
);

   logic [W-1:0] mem [N];

   // No reset on purpose: keeps the array mappable onto block RAM.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         for (int p = 0; p < 3; p++) begin
            rdata[p] <= mem[raddr[p]];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/mt_state_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mt_state_bank : Mersenne Twister state store with twist-tuple sequencing  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module mt_state_bank
   import mt_state_bank_pkg::*;
#(
   parameter int W = MT_W,
   parameter int N = MT_N,
   parameter int M = MT_M
) (
   input  wire logic       clk,
   input  wire logic       rst,
   mt_state_bank_if.slave  bus
);

   localparam int            AW      = $clog2(N);
   localparam logic [AW-1:0] C_LAST  = AW'(N - 1);
   localparam logic [AW:0]   C_N_EXT = (AW + 1)'(N);
   localparam logic [AW:0]   C_M_EXT = (AW + 1)'(M);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [AW-1:0]       r_ptr;
   logic [AW-1:0]       r_clr_addr;
   logic [2:0][AW-1:0]  r_raddr;
   logic                r_seed_err;
   logic                r_wrap;

   logic [2:0][W-1:0]   w_rdata;
   logic                w_seed_ok;
   logic                w_req_acc;
   logic                w_wb_acc;
   logic                w_tup_valid;
   logic [AW:0]         w_im_sum;
   logic [AW-1:0]       w_addr_i1;
   logic [AW-1:0]       w_addr_im;
   logic                w_we;
   logic [AW-1:0]       w_waddr;
   logic [W-1:0]        w_wdata;

   assign w_seed_ok = (r_state == S_IDLE) && !bus.clear &&
                      ({1'b0, bus.seed_addr} < C_N_EXT);
   assign w_req_acc = (r_state == S_IDLE) && !bus.clear && bus.req_valid;
   assign w_wb_acc  = (r_state == S_WB) && !bus.clear && bus.wb_valid;

   // Neighbour addresses wrap by compare-subtract; ptr+M < 2N always holds.
   assign w_addr_i1 = (r_ptr == C_LAST) ? '0 : r_ptr + 1'b1;
   assign w_im_sum  = {1'b0, r_ptr} + C_M_EXT;
   assign w_addr_im = (w_im_sum >= C_N_EXT) ? AW'(w_im_sum - C_N_EXT) : w_im_sum[AW-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (bus.clear) begin
         w_state_nxt = S_CLEAR;
      end else begin
         case (r_state)
            S_CLEAR: if (r_clr_addr == C_LAST) w_state_nxt = S_IDLE;
            S_IDLE:  if (bus.req_valid) w_state_nxt = S_RD;
            S_RD:    w_state_nxt = S_WB;
            S_WB:    if (bus.wb_valid) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr      <= '0;
         r_clr_addr <= '0;
         r_raddr    <= '0;
         r_seed_err <= 1'b0;
         r_wrap     <= 1'b0;
      end else begin
         r_seed_err <= bus.seed_we && !w_seed_ok;
         r_wrap     <= 1'b0;
         if (bus.clear) begin
            r_ptr      <= '0;
            r_clr_addr <= '0;
         end else begin
            if (r_state == S_CLEAR) begin
               r_clr_addr <= (r_clr_addr == C_LAST) ? '0 : r_clr_addr + 1'b1;
            end
            if (w_req_acc) begin
               r_raddr <= {w_addr_im, w_addr_i1, r_ptr};
            end
            if (w_wb_acc) begin
               r_ptr  <= (r_ptr == C_LAST) ? '0 : r_ptr + 1'b1;
               r_wrap <= (r_ptr == C_LAST);
            end
         end
      end
   end

   // Write priority: clear fill, then seed, then twist write-back.
   always_comb begin
      w_we    = 1'b0;
      w_waddr = r_ptr;
      w_wdata = bus.wb_data;
      if (r_state == S_CLEAR) begin
         w_we    = 1'b1;
         w_waddr = r_clr_addr;
         w_wdata = '0;
      end else if (bus.seed_we && w_seed_ok) begin
         w_we    = 1'b1;
         w_waddr = bus.seed_addr;
         w_wdata = bus.seed_data;
      end else if (w_wb_acc) begin
         w_we    = 1'b1;
      end
      if (rst) begin
         w_we = 1'b0;
      end
   end

   mt_ram_1w3r #(
      .W (W),
      .N (N)
   ) u_ram (
      .clk   (clk),
      .we    (w_we),
      .waddr (w_waddr),
      .wdata (w_wdata),
      .re    (r_state == S_RD),
      .raddr (r_raddr),
      .rdata (w_rdata)
   );

   assign w_tup_valid   = (r_state == S_WB);
   assign bus.tup_valid = w_tup_valid;
   assign bus.busy      = (r_state == S_CLEAR);
   assign bus.req_ready = (r_state == S_IDLE) && !rst;
   assign bus.tup_idx   = w_tup_valid ? r_ptr : '0;
   assign bus.x_i       = w_tup_valid ? w_rdata[0] : '0;
   assign bus.x_i1      = w_tup_valid ? w_rdata[1] : '0;
   assign bus.x_im      = w_tup_valid ? w_rdata[2] : '0;
   assign bus.seed_err  = r_seed_err;
   assign bus.wrap      = r_wrap;

endmodule
`default_nettype wire
